// File: rtl/hdd_pkg.sv
// hdd_pkg: types and constants shared by the ProDOS HDD block-server engine.
//   hdd_state_t : transfer sequencer states
//   hdd_op_t    : block operation (read = host -> buffer, write = buffer -> host)
//   hdd_req_t   : latched request (operation + absolute LBA)
package hdd_pkg;

  localparam int HDD_BLOCK_BYTES = 512;
  localparam int HDD_ADDR_W      = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_FINISH
  } hdd_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } hdd_op_t;

  typedef struct packed {
    hdd_op_t     op;
    logic [31:0] lba;
  } hdd_req_t;

endpackage

// File: rtl/hdd_block_server.sv
// hdd_block_server: services the HDD card's block read/write pulses against
// the host block-device port and moves the 512-byte block through the card's
// sector buffer.
//
// Ports:
//   CLK_14M, RESET_N          clock, async active-low reset
//   hdd_read/hdd_write/sector one-cycle request pulse + block number
//   ram_addr/ram_di/ram_we    sector-buffer write side (read ops)
//   ram_do                    sector-buffer read data, 1-cycle latency
//   sd_lba/sd_rd/sd_wr        host request
//   sd_ack                    host data phase active
//   sd_buff_addr/dout/wr      host byte stream (read ops)
//   sd_buff_din               buffer bytes to host (write ops)
//   busy/done/err             CPU halt, completion pulse, sticky error
//
// Build option: HDD_BLOCK_SERVER_TIMEOUT_EN adds a watchdog that aborts a
// transfer after TIMEOUT_CYCLES in REQ/XFER. Without it the engine waits
// indefinitely for the host.
module hdd_block_server
  import hdd_pkg::*;
#(
  parameter logic [31:0] LBA_BASE       = 32'd0,
  parameter int          TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                  CLK_14M,
  input  logic                  RESET_N,
  input  logic                  hdd_read,
  input  logic                  hdd_write,
  input  logic [15:0]           sector,
  output logic [HDD_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_di,
  output logic                  ram_we,
  input  logic [7:0]            ram_do,
  output logic [31:0]           sd_lba,
  output logic                  sd_rd,
  output logic                  sd_wr,
  input  logic                  sd_ack,
  input  logic [HDD_ADDR_W-1:0] sd_buff_addr,
  input  logic [7:0]            sd_buff_dout,
  input  logic                  sd_buff_wr,
  output logic [7:0]            sd_buff_din,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  hdd_state_t            state, state_n;
  hdd_op_t               cur_op;
  hdd_req_t              pend, req_new, launch_req;
  logic                  pend_vld;
  logic [HDD_ADDR_W-1:0] ram_addr_q;
  logic                  req_any, can_launch, launch, direct, slot_load, slot_ovf;
  logic                  tmo_hit;

  // Write wins a simultaneous pulse; the read is dropped and flagged below.
  assign req_any     = hdd_read | hdd_write;
  assign req_new.op  = hdd_write ? OP_WRITE : OP_READ;
  assign req_new.lba = LBA_BASE + {16'h0000, sector};

  // A new transfer can start from IDLE or straight out of FINISH. A waiting
  // slot entry always goes first; a fresh pulse then takes its place.
  assign can_launch = (state == ST_IDLE) || (state == ST_FINISH);
  assign launch     = can_launch && (pend_vld || req_any);
  assign launch_req = pend_vld ? pend : req_new;
  assign direct     = can_launch && !pend_vld && req_any;
  assign slot_load  = req_any && !direct;
  assign slot_ovf   = req_any && pend_vld && !can_launch;

`ifdef HDD_BLOCK_SERVER_TIMEOUT_EN
  localparam logic [21:0] TMO_LAST = 22'(TIMEOUT_CYCLES - 1);
  logic [21:0] tmo_cnt;

  // One budget covers the whole request + data phase.
  assign tmo_hit = ((state == ST_REQ) || (state == ST_XFER)) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N)
      tmo_cnt <= '0;
    else if (((state == ST_REQ) || (state == ST_XFER)) && !tmo_hit)
      tmo_cnt <= tmo_cnt + 22'd1;
    else
      tmo_cnt <= '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (launch) state_n = ST_REQ;
      ST_REQ:    if (sd_ack) state_n = ST_XFER;
      ST_XFER:   if (!sd_ack) state_n = ST_FINISH;
      ST_FINISH: state_n = launch ? ST_REQ : ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
    if (tmo_hit) state_n = ST_IDLE;
  end

  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge CLK_14M or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_op     <= OP_READ;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr_q <= '0;
      ram_di     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      pend_vld   <= 1'b0;
      pend       <= '0;
    end else begin
      if (launch) begin
        cur_op <= launch_req.op;
        sd_lba <= launch_req.lba;
        sd_rd  <= (launch_req.op == OP_READ);
        sd_wr  <= (launch_req.op == OP_WRITE);
      end else if ((state == ST_REQ && sd_ack) || tmo_hit) begin
        sd_rd <= 1'b0;
        sd_wr <= 1'b0;
      end

      // Host bytes land in the buffer one cycle after their strobe.
      ram_we <= (state == ST_XFER) && (cur_op == OP_READ) && sd_buff_wr;
      if ((state == ST_XFER) && (cur_op == OP_READ) && sd_buff_wr) begin
        ram_addr_q <= sd_buff_addr;
        ram_di     <= sd_buff_dout;
      end

      done <= ((state == ST_XFER) && !sd_ack) || tmo_hit;

      if (slot_load) begin
        pend_vld <= 1'b1;
        pend     <= req_new;
      end else if (launch && pend_vld) begin
        pend_vld <= 1'b0;
      end

      // A directly accepted pulse clears the sticky flag; errors in the same
      // cycle still win.
      if ((hdd_read && hdd_write) || slot_ovf || tmo_hit) err <= 1'b1;
      else if (direct)                                    err <= 1'b0;
    end
  end

  // Write ops feed the buffer address straight through so ram_do lines up
  // with the host one cycle later.
  assign ram_addr    = (state == ST_XFER && cur_op == OP_WRITE) ? sd_buff_addr : ram_addr_q;
  assign sd_buff_din = ram_do;
  assign busy        = (state != ST_IDLE) || pend_vld;

endmodule

// File: doc/hdd_block_server.md
# hdd_block_server

Host-side servicing engine for the ProDOS HDD card. It accepts the card's one-cycle `hdd_read`/`hdd_write` requests and block number, runs the 512-byte block transfer against the system block-device port (sd_* handshake), and fills or drains the card's dual-ported sector buffer through its `ram_*` port. It sits between the HDD card and the top-level SD/image interface, and drives a busy flag used to halt the CPU during a transfer.

## Interface
- `LBA_BASE`, default 0: 32-bit offset added to the 16-bit block number.
- `TIMEOUT_CYCLES`, default 2_000_000: abort threshold. Used only with the timeout feature.
- `CLK_14M  in  1`: system clock. Single clock domain.
- `RESET_N  in  1`: asynchronous, active-low reset.
- `hdd_read  in  1`: read-block request pulse from the card.
- `hdd_write  in  1`: write-block request pulse from the card.
- `sector  in  16`: block number. Sampled in the same cycle as the request pulse.
- `ram_addr  out  9`: sector-buffer address.
- `ram_di  out  8`: data written into the sector buffer.
- `ram_we  out  1`: sector-buffer write enable.
- `ram_do  in  8`: sector-buffer read data. Registered, with 1-cycle latency.
- `sd_lba  out  32`: block address presented to the host.
- `sd_rd  out  1`: host read request (host → buffer).
- `sd_wr  out  1`: host write request (buffer → host).
- `sd_ack  in  1`: host acknowledge. High for the whole data phase.
- `sd_buff_addr  in  9`: byte index driven by the host.
- `sd_buff_dout  in  8`: host data for a read.
- `sd_buff_wr  in  1`: host byte strobe for a read.
- `sd_buff_din  out  8`: buffer data for a write. Equals `ram_do`.
- `busy  out  1`: a transfer is in progress or pending.
- `done  out  1`: one-cycle pulse when a transfer completes.
- `err  out  1`: sticky overflow/timeout flag. Cleared by the next accepted request.

## Operation
- States: IDLE, REQ, XFER, FINISH.
- IDLE, on a request pulse:
  - Latch the operation and `sd_lba = LBA_BASE + sector` (32-bit add, no saturation, wraps modulo 2^32).
  - Set `busy`.
  - Go to REQ.
- REQ:
  - Drive `sd_rd` (read) or `sd_wr` (write).
  - When `sd_ack` is sampled high, drop the request line and go to XFER.
- XFER, read operation:
  - Each cycle with `sd_buff_wr` high registers `ram_addr = sd_buff_addr`, `ram_di = sd_buff_dout`, `ram_we = 1` for exactly one cycle.
- XFER, write operation:
  - `ram_addr = sd_buff_addr` combinationally; `ram_we = 0`.
  - `sd_buff_din = ram_do`, valid one cycle after the address.
- XFER exit: when `sd_ack` is sampled low, go to FINISH.
- FINISH: pulse `done`, then go to IDLE.
  - If a request is pending, go directly back to REQ with the pending parameters; `busy` stays high.
- Simultaneous `hdd_read` and `hdd_write`: write wins; read is discarded and `err` is set.
- Request while not IDLE: stored in a one-deep pending slot (op + lba).
  - A second request while the slot is full overwrites the slot and sets `err`.
- The byte count is defined by the host; a transfer of fewer than 512 bytes is legal, and unwritten bytes keep their old contents.
- Reset mid-operation: all state is cleared asynchronously and any pending request is dropped. The host is expected to be reset together with this block.

## Timing
- Reset values: `sd_rd = sd_wr = 0`, `sd_lba = 0`, `ram_we = 0`, `ram_addr = 0`, `ram_di = 0`, `busy = 0`, `done = 0`, `err = 0`.
- Request pulse in cycle N → `busy`, `sd_lba` and `sd_rd`/`sd_wr` all high in N+1.
- `sd_ack` first high in cycle M → request line low in M+1.
- Read byte: `sd_buff_wr` in cycle K → `ram_we` high in K+1.
- `sd_ack` falls in cycle F → `done` high in F+1 → `busy` low in F+2, unless a request is pending.
- Minimum idle-to-idle transfer: 4 cycles plus the host data phase.

## Configuration
- `HDD_BLOCK_SERVER_TIMEOUT_EN` defined:
  - A 22-bit counter runs in REQ and XFER.
  - Reaching `TIMEOUT_CYCLES` drops `sd_rd`/`sd_wr`, sets `err`, pulses `done` and returns to IDLE. The pending slot is kept.
- Undefined: no counter is built; the engine waits indefinitely for the host.

## Structure
- Shared package `hdd_pkg`:
  - State enum.
  - `HDD_BLOCK_BYTES = 512`, `HDD_ADDR_W = 9`.
  - Op enum: OP_READ, OP_WRITE.
- Single module; no sub-module. The timeout counter is inline under the macro.

## Test plan
- Read of `sector = 16'h0005` with `LBA_BASE = 100`:
  - `sd_lba = 105` and `sd_rd` high next cycle.
  - Host acks and streams bytes 0..511 with value = addr[7:0].
  - Buffer holds the pattern; `done` pulses once; `busy` low two cycles after `sd_ack` falls.
- Write of block 7 with the buffer preloaded as addr ^ 8'hA5:
  - `sd_wr` high until ack.
  - `sd_buff_din` at address a, one cycle later, equals a ^ 8'hA5 for all 512 addresses.
  - `ram_we` never high.
- `hdd_write` during an active read: the second transfer starts immediately after FINISH without dropping `busy`; a third pulse during the first sets `err`.
- Simultaneous read and write pulse: a write is issued and `err` = 1.
- With the macro defined and `TIMEOUT_CYCLES = 50`, no `sd_ack` for 50 cycles: `sd_rd` drops, `err` = 1, `done` pulses.
- Assert `RESET_N` low mid-XFER: all outputs return to their reset values in the same cycle; after release, a new read completes normally.
